dual_writeback: RTL
===================

Name: dual_writeback

Overview:
- Two-lane writeback stage; the producer side of the dual-port register-file write interface.
- Registers results from both execute lanes and resolves same-cycle write-after-write conflicts.
- Drives the regfile A/B write ports (rd_addr/rd_data/rd_write per lane).
- Maintains a busy scoreboard of in-flight destination registers that the issue stage reads to detect RAW hazards.

Parameters:
- XLEN, 32, data width of results and regfile entries
- NREGS, 32, architectural register count; address width is log2(NREGS)

Ports:
- clock_i  in  1  sole clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- iss_rd_addr0_i  in  5  destination of lane-0 instruction issued this cycle
- iss_rd_valid0_i  in  1  lane-0 issued instruction writes a register
- iss_rd_addr1_i  in  5  destination of lane-1 (younger) instruction issued this cycle
- iss_rd_valid1_i  in  1  lane-1 issued instruction writes a register
- ex_rd_addr0_i  in  5  lane-0 execute result destination
- ex_rd_data0_i  in  XLEN  lane-0 execute result
- ex_write0_i  in  1  lane-0 result valid and writes rd
- ex_rd_addr1_i  in  5  lane-1 execute result destination
- ex_rd_data1_i  in  XLEN  lane-1 execute result
- ex_write1_i  in  1  lane-1 result valid and writes rd
- stall_i  in  1  hold the writeback register; upstream holds its ex_* inputs
- rd_addr0_o  out  5  regfile port A write address
- rd_data0_o  out  XLEN  regfile port A write data
- rd_write0_o  out  1  regfile port A write enable
- rd_addr1_o  out  5  regfile port B write address
- rd_data1_o  out  XLEN  regfile port B write data
- rd_write1_o  out  1  regfile port B write enable
- busy_o  out  NREGS  bit n set = register n has an uncommitted write in flight

Behaviour:
- Reset (asynchronous, reset_i=1): all rd_*_o = 0, busy_o = 0, writeback register cleared. Reset asserted mid-operation discards in-flight results; busy bits are not retained.
- Latency: ex_* sampled at a rising edge with stall_i=0 appear on rd_*_o in the following cycle. The regfile commits them at the next edge, so end-to-end latency is one register stage.
- x0 rule:
  - A captured entry with addr=0 forces its write enable to 0.
  - busy_o[0] is constant 0.
- WAW resolution at capture: if ex_write0_i & ex_write1_i & (ex_rd_addr0_i==ex_rd_addr1_i), the lane-0 write enable is cleared. Lane 1 (younger) wins.
- Stall:
  - stall_i=1 holds the writeback register and forces rd_write0_o = rd_write1_o = 0.
  - On the first cycle with stall_i=0, the held entries drive their writes.
  - ex_* inputs presented during a stall are not captured.
- Scoreboard update per edge, evaluated in this order:
  - clear busy[rd_addr0_o] if rd_write0_o;
  - clear busy[rd_addr1_o] if rd_write1_o;
  - set busy[iss_rd_addr0_i] if iss_rd_valid0_i;
  - set busy[iss_rd_addr1_i] if iss_rd_valid1_i.
  - A set and a clear on the same register in the same cycle: set wins (new producer).
  - Both issue lanes naming the same rd: the bit is set once.
  - Issue with addr 0: ignored.
- busy_o is registered; issue sees an update one cycle after the triggering edge.
- No bypass data is produced; forwarding lives elsewhere.

Decomposition:
- defs.v gets REG_ADDR_W (5) and XLEN.
- One sub-module, wb_scoreboard:
  - owns the NREGS busy vector;
  - applies the set/clear priority rule;
  - exposes busy_o.
- dual_writeback holds the two-entry writeback register and the WAW/x0 masking, and instantiates wb_scoreboard.

Test Plan:
- Reset mid-stream: write captured to x5 and busy[5]=1, then reset_i pulse -> rd_write0_o=0, rd_write1_o=0, busy_o=0 immediately, without waiting for a clock edge.
- Basic pipeline: ex lane0 (x3, 0xDEADBEEF) and lane1 (x4, 0x12345678) with stall_i=0 -> next cycle rd_addr0_o=3, rd_data0_o=0xDEADBEEF, rd_write0_o=1, rd_addr1_o=4, rd_data1_o=0x12345678, rd_write1_o=1.
- WAW: both lanes write x7 (lane0 0x11, lane1 0x22) -> rd_write0_o=0, rd_write1_o=1, rd_data1_o=0x22; after commit, regfile x7=0x22.
- x0: lane0 writes x0 with data 0xFFFFFFFF -> rd_write0_o=0. Issue of rd=0 -> busy_o[0] stays 0.
- Scoreboard set-wins: issue x9 (busy[9]=1); when its writeback drives x9, issue another x9 in the same cycle -> busy[9] remains 1. With no new issue, busy[9] returns to 0 after the commit edge.
- Stall: capture x10 (0xAA), then assert stall_i for 3 cycles while changing ex_* inputs:
  - rd_write outputs stay 0 throughout and busy[10] stays 1;
  - on release, rd_addr0_o=10, rd_data0_o=0xAA with rd_write0_o=1 for one cycle;
  - the changed ex_* values were not captured.

Source files
------------

// File: rtl/dual_writeback_pkg.sv
// Shared widths and helpers for the dual-lane writeback stage.
// Holds the register-address width, default data width and the WAW/x0 write-enable rule.
package dual_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREGS  = 32;

  // Write enable of a captured lane: never for x0, and the older
  // lane yields to a younger lane writing the same register.
  function automatic logic lane_we(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  kill
  );
    return we & (addr != '0) & ~kill;
  endfunction

endpackage

// File: rtl/dual_writeback_scoreboard.sv
// wb_scoreboard: busy bit per architectural register.
// Ports: clk/rst, two clear requests (commits), two set requests (issues), busy_o.
module wb_scoreboard
  import dual_writeback_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] clr_addr0_i,
  input  logic                  clr0_i,
  input  logic [REG_ADDR_W-1:0] clr_addr1_i,
  input  logic                  clr1_i,
  input  logic [REG_ADDR_W-1:0] set_addr0_i,
  input  logic                  set0_i,
  input  logic [REG_ADDR_W-1:0] set_addr1_i,
  input  logic                  set1_i,
  output logic [NREGS-1:0]      busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clears first, then sets: a new producer issued in the
  // same cycle as an older commit keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (clr0_i) busy_d[clr_addr0_i] = 1'b0;
    if (clr1_i) busy_d[clr_addr1_i] = 1'b0;
    if (set0_i) busy_d[set_addr0_i] = 1'b1;
    if (set1_i) busy_d[set_addr1_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/dual_writeback.sv
// Two-lane writeback register with WAW/x0 masking driving regfile ports A/B.
// Ports: iss_* (issue dests), ex_* (execute results), stall_i, rd_* (regfile writes), busy_o.
module dual_writeback
  import dual_writeback_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_addr0_i,
  input  logic                  iss_rd_valid0_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_addr1_i,
  input  logic                  iss_rd_valid1_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr0_i,
  input  logic [XLEN-1:0]       ex_rd_data0_i,
  input  logic                  ex_write0_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr1_i,
  input  logic [XLEN-1:0]       ex_rd_data1_i,
  input  logic                  ex_write1_i,
  input  logic                  stall_i,
  output logic [REG_ADDR_W-1:0] rd_addr0_o,
  output logic [XLEN-1:0]       rd_data0_o,
  output logic                  rd_write0_o,
  output logic [REG_ADDR_W-1:0] rd_addr1_o,
  output logic [XLEN-1:0]       rd_data1_o,
  output logic                  rd_write1_o,
  output logic [NREGS-1:0]      busy_o
);

  logic [REG_ADDR_W-1:0] wb_addr0;
  logic [REG_ADDR_W-1:0] wb_addr1;
  logic [XLEN-1:0]       wb_data0;
  logic [XLEN-1:0]       wb_data1;
  logic                  wb_we0;
  logic                  wb_we1;

  logic waw;
  logic cap_we0;
  logic cap_we1;

  assign waw = ex_write0_i & ex_write1_i
             & (ex_rd_addr0_i == ex_rd_addr1_i);

  assign cap_we0 = lane_we(ex_write0_i, ex_rd_addr0_i, waw);
  assign cap_we1 = lane_we(ex_write1_i, ex_rd_addr1_i, 1'b0);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wb_addr0 <= '0;
      wb_data0 <= '0;
      wb_we0   <= 1'b0;
      wb_addr1 <= '0;
      wb_data1 <= '0;
      wb_we1   <= 1'b0;
    end else if (!stall_i) begin
      wb_addr0 <= ex_rd_addr0_i;
      wb_data0 <= ex_rd_data0_i;
      wb_we0   <= cap_we0;
      wb_addr1 <= ex_rd_addr1_i;
      wb_data1 <= ex_rd_data1_i;
      wb_we1   <= cap_we1;
    end
  end

  // A held entry only writes once the stall drops.
  assign rd_addr0_o  = wb_addr0;
  assign rd_data0_o  = wb_data0;
  assign rd_write0_o = wb_we0 & ~stall_i;
  assign rd_addr1_o  = wb_addr1;
  assign rd_data1_o  = wb_data1;
  assign rd_write1_o = wb_we1 & ~stall_i;

  wb_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clr_addr0_i (wb_addr0),
    .clr0_i      (rd_write0_o),
    .clr_addr1_i (wb_addr1),
    .clr1_i      (rd_write1_o),
    .set_addr0_i (iss_rd_addr0_i),
    .set0_i      (iss_rd_valid0_i),
    .set_addr1_i (iss_rd_addr1_i),
    .set1_i      (iss_rd_valid1_i),
    .busy_o      (busy_o)
  );

endmodule
